// File: rtl/uart_sha256_framer_if.sv
// rtl/uart_sha256_framer_if.sv - signal bundle between the framer, the UART cores and the SHA core
//
// Purpose: groups the byte streams, the SHA core handshake and the status outputs.
// Modports:
//   master  framer side: drives tx_data/tx_start, sha_start/sha_data/sha_valid/sha_last,
//           busy, err_code; samples rx_data/rx_valid, tx_busy, hash_out/hash_done
//   slave   environment side (UART cores, SHA core): the mirror image of master
interface uart_sha256_framer_if;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         tx_busy;
  logic         sha_start;
  logic [7:0]   sha_data;
  logic         sha_valid;
  logic         sha_last;
  logic [255:0] hash_out;
  logic         hash_done;
  logic         busy;
  logic [7:0]   err_code;

  modport master (
    input  rx_data, rx_valid, tx_busy, hash_out, hash_done,
    output tx_data, tx_start, sha_start, sha_data, sha_valid, sha_last, busy, err_code
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, hash_out, hash_done,
    input  tx_data, tx_start, sha_start, sha_data, sha_valid, sha_last, busy, err_code
  );
endinterface

// File: rtl/uart_sha256_framer.sv
// rtl/uart_sha256_framer.sv - length-prefixed UART framing bridge for a SHA-256 core
//
// Purpose: accepts SOF, a big-endian length field and the payload from a UART RX core,
// streams the payload into the SHA core, then answers through the UART TX core with a
// status byte (00 ok, E1 bad length, E2 inter-byte timeout) followed, on success, by the
// leading DIGEST_BYTES bytes of the digest.
// Config macro: UART_SHA256_HEX_OUT_EN - when defined each digest byte is sent as two
// lowercase ASCII hex characters, high nibble first; when undefined the digest is raw.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    uart_sha256_framer_if.master: rx_data/rx_valid in, tx_data/tx_start out,
//          tx_busy in, sha_start/sha_data/sha_valid/sha_last out, hash_out/hash_done in,
//          busy/err_code out
module uart_sha256_framer #(
  parameter logic [7:0] SOF          = 8'h01,
  parameter int         LEN_BYTES    = 2,
  parameter int         MAX_LEN      = 1024,
  parameter int         DIGEST_BYTES = 32,
  parameter int         TIMEOUT_CYC  = 868000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  uart_sha256_framer_if.master        bus
);
  localparam int LW = 8 * LEN_BYTES;
  localparam int IW = $clog2(DIGEST_BYTES + 1);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_BADLEN = 8'hE1;
  localparam logic [7:0] ST_TMO    = 8'hE2;

  typedef enum logic [2:0] {IDLE, LEN, DATA, WAIT, STAT, DIG, FLUSH} state_t;
  state_t state, state_nx;

  logic [LW-1:0]  len_reg;   // length while in LEN, remaining payload bytes in DATA
  logic [2:0]     len_cnt;
  logic [TW-1:0]  tmr;
  logic [255:0]   hash_reg;  // shifted left one byte per digest byte sent
  logic [IW-1:0]  idx;
`ifdef UART_SHA256_HEX_OUT_EN
  logic           nib;       // 0: high nibble next, 1: low nibble next

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction
`endif

  logic [LW-1:0] len_next;
  logic          len_bad, len_last, tmo, tx_ok, dig_last;
  logic          sha_fwd, start_nx, tx_fire;
  logic [7:0]    tx_byte, err_nx;

  assign len_next = (len_reg << 8) | LW'(bus.rx_data);
  // Compare in 33 bits so MAX_LEN above the field's range never truncates.
  assign len_bad  = (len_next == '0) || (33'(len_next) > 33'(MAX_LEN));
  assign len_last = (len_cnt == 3'(LEN_BYTES - 1));
  // A byte arriving on the terminal count cancels the timeout.
  assign tmo      = (TIMEOUT_CYC != 0) && !bus.rx_valid && (tmr == TW'(TIMEOUT_CYC - 1))
                    && (state == LEN || state == DATA);
  // tx_start is only raised on an idle TX core and never on consecutive cycles.
  assign tx_ok    = !bus.tx_busy && !bus.tx_start;
`ifdef UART_SHA256_HEX_OUT_EN
  assign dig_last = (idx == IW'(DIGEST_BYTES - 1)) && nib;
`else
  assign dig_last = (idx == IW'(DIGEST_BYTES - 1));
`endif
  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (bus.rx_valid && bus.rx_data == SOF) state_nx = LEN;
      LEN:   if (bus.rx_valid) begin
               if (len_last) state_nx = len_bad ? STAT : DATA;
             end else if (tmo) state_nx = STAT;
      DATA:  if (bus.rx_valid) begin
               if (len_reg == LW'(1)) state_nx = WAIT;
             end else if (tmo) state_nx = STAT;
      WAIT:  if (bus.hash_done) state_nx = STAT;
      STAT:  if (tx_ok) state_nx = (bus.err_code == ST_OK) ? DIG : FLUSH;
      DIG:   if (tx_ok && dig_last) state_nx = FLUSH;
      FLUSH: if (tx_ok) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sha_fwd  = 1'b0;
    start_nx = 1'b0;
    tx_fire  = 1'b0;
    tx_byte  = 8'h00;
    err_nx   = bus.err_code;
    case (state)
      LEN: begin
        if (bus.rx_valid && len_last) begin
          if (len_bad) err_nx = ST_BADLEN;
          else         start_nx = 1'b1;
        end else if (tmo) err_nx = ST_TMO;
      end
      DATA: begin
        sha_fwd = bus.rx_valid;
        if (tmo) err_nx = ST_TMO;
      end
      WAIT: if (bus.hash_done) err_nx = ST_OK;
      STAT: begin
        tx_fire = tx_ok;
        tx_byte = bus.err_code;
      end
      DIG: begin
        tx_fire = tx_ok;
`ifdef UART_SHA256_HEX_OUT_EN
        tx_byte = nib ? hex_char(hash_reg[251:248]) : hex_char(hash_reg[255:252]);
`else
        tx_byte = hash_reg[255:248];
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_reg       <= '0;
      len_cnt       <= '0;
      tmr           <= '0;
      hash_reg      <= '0;
      idx           <= '0;
`ifdef UART_SHA256_HEX_OUT_EN
      nib           <= 1'b0;
`endif
      bus.tx_data   <= '0;
      bus.tx_start  <= 1'b0;
      bus.sha_start <= 1'b0;
      bus.sha_data  <= '0;
      bus.sha_valid <= 1'b0;
      bus.sha_last  <= 1'b0;
      bus.err_code  <= '0;
    end else begin
      bus.err_code  <= err_nx;
      bus.sha_start <= start_nx;
      bus.sha_valid <= sha_fwd;
      bus.sha_last  <= sha_fwd && (len_reg == LW'(1));
      bus.tx_start  <= tx_fire;
      if (sha_fwd) bus.sha_data <= bus.rx_data;
      if (tx_fire) bus.tx_data  <= tx_byte;
      if (bus.rx_valid || !(state == LEN || state == DATA)) tmr <= '0;
      else                                                  tmr <= tmr + TW'(1);
      case (state)
        IDLE: begin
          len_reg <= '0;
          len_cnt <= '0;
        end
        LEN: if (bus.rx_valid) begin
          len_reg <= len_next;
          len_cnt <= len_cnt + 3'd1;
        end
        DATA: if (bus.rx_valid) len_reg <= len_reg - LW'(1);
        WAIT: if (bus.hash_done) hash_reg <= bus.hash_out;
        STAT: begin
          idx <= '0;
`ifdef UART_SHA256_HEX_OUT_EN
          nib <= 1'b0;
`endif
        end
        DIG: if (tx_fire) begin
`ifdef UART_SHA256_HEX_OUT_EN
          nib <= !nib;
          if (nib) begin
            idx      <= idx + IW'(1);
            hash_reg <= {hash_reg[247:0], 8'h00};
          end
`else
          idx      <= idx + IW'(1);
          hash_reg <= {hash_reg[247:0], 8'h00};
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_sha256_framer.sv
// tb/tb_uart_sha256_framer.sv - scoreboard bench for uart_sha256_framer
`timescale 1ns/1ps
module tb_uart_sha256_framer;
  localparam int         LEN_BYTES   = 2;
  localparam int         MAX_LEN     = 1024;
  localparam int         DIG_BYTES   = 32;
  localparam int         TIMEOUT_CYC = 300;
  localparam logic [7:0] SOF         = 8'h01;
  localparam logic [255:0] ABC_HASH =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_sha256_framer_if bus();

  uart_sha256_framer #(
    .SOF(SOF), .LEN_BYTES(LEN_BYTES), .MAX_LEN(MAX_LEN),
    .DIGEST_BYTES(DIG_BYTES), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_tx[$];
  logic [8:0] exp_sha[$];   // {last, data}
  logic [7:0] pl[$];
  logic [7:0] gb[$];
  logic [255:0] cur_hash;
  int tx_seen = 0;
  int sha_starts = 0;
  int base_tx, base_starts;
  logic [7:0] exp_st;
  bit exp_bad;
  string hx = "0123456789abcdef";

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.tx_start, bus.tx_data, bus.sha_start, bus.sha_data, bus.sha_valid,
                bus.sha_last, bus.busy, bus.err_code});
  endfunction

  // TX core model plus output monitor; all sampling on the falling edge.
  initial begin
    int bcnt;
    logic prev_start;
    bcnt = 0;
    prev_start = 1'b0;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.sha_start) sha_starts++;
      if (bus.sha_valid) begin
        chk("sha_pending", 64'(exp_sha.size() > 0), 64'd1);
        if (exp_sha.size() > 0) chk("sha_byte", 64'({bus.sha_last, bus.sha_data}), 64'(exp_sha.pop_front()));
      end
      if (bus.tx_start) begin
        chk("tx_rule", 64'({bus.tx_busy, prev_start}), 64'd0);
        chk("tx_pending", 64'(exp_tx.size() > 0), 64'd1);
        if (exp_tx.size() > 0) chk("tx_byte", 64'(bus.tx_data), 64'(exp_tx.pop_front()));
        tx_seen++;
        bcnt = $urandom_range(1, 4);
      end else if (bcnt > 0) bcnt--;
      bus.tx_busy = (bcnt > 0);
      prev_start = bus.tx_start;
    end
  end

  // SHA core model: returns cur_hash a few cycles after the final payload byte.
  initial begin
    bus.hash_done = 1'b0;
    bus.hash_out = '0;
    forever begin
      @(negedge clk);
      bus.hash_done = 1'b0;
      if (bus.sha_valid && bus.sha_last) begin
        repeat ($urandom_range(1, 8)) @(negedge clk);
        bus.hash_out = cur_hash;
        bus.hash_done = 1'b1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic start_frame(input int len_field, input int n_send, input bit inject, input int gap_max);
    logic [7:0] b;
    int c;
    exp_bad = (len_field == 0) || (len_field > MAX_LEN);
    exp_st = exp_bad ? 8'hE1 : (n_send < len_field) ? 8'hE2 : 8'h00;
    exp_tx.push_back(exp_st);
    if (exp_st == 8'h00)
      for (int i = 0; i < DIG_BYTES; i++) begin
        b = 8'(cur_hash >> (248 - 8 * i));
`ifdef UART_SHA256_HEX_OUT_EN
        exp_tx.push_back(hx[b[7:4]]);
        exp_tx.push_back(hx[b[3:0]]);
`else
        exp_tx.push_back(b);
`endif
      end
    if (!exp_bad)
      for (int i = 0; i < n_send; i++) exp_sha.push_back({i == len_field - 1, pl[i]});
    base_tx = tx_seen;
    base_starts = sha_starts;
    foreach (gb[i]) send_byte(gb[i], $urandom_range(0, gap_max));
    send_byte(SOF, $urandom_range(0, gap_max));
    for (int i = LEN_BYTES - 1; i >= 0; i--) send_byte(8'(len_field >> (8 * i)), $urandom_range(0, gap_max));
    if (!exp_bad)
      for (int i = 0; i < n_send; i++) send_byte(pl[i], $urandom_range(0, gap_max));
    if (inject) begin
      c = 0;
      while (tx_seen < base_tx + 3 && c < 5000) begin @(negedge clk); c++; end
      chk("inject_in_dig", 64'(tx_seen >= base_tx + 3), 64'd1);
      send_byte(SOF, 1);
      send_byte(8'h00, 1);
      send_byte(8'h03, 1);
    end
  endtask

  task automatic finish_frame();
    int c;
    c = 0;
    while (bus.busy && c < TIMEOUT_CYC + 20000) begin @(negedge clk); c++; end
    chk("busy_after_frame", 64'(bus.busy), 64'd0);
    chk("err_code", 64'(bus.err_code), 64'(exp_st));
    chk("tx_left", 64'(exp_tx.size()), 64'd0);
    chk("sha_left", 64'(exp_sha.size()), 64'd0);
    chk("sha_start_count", 64'(sha_starts - base_starts), exp_bad ? 64'd0 : 64'd1);
    exp_tx.delete();
    exp_sha.delete();
    gb.delete();
  endtask

  task automatic rand_payload(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom()));
  endtask

  task automatic rand_hash();
    for (int k = 0; k < 8; k++) cur_hash[32 * k +: 32] = $urandom();
  endtask

  initial begin
    int c, len;
    bus.rx_data = '0;
    bus.rx_valid = 1'b0;
    cur_hash = ABC_HASH;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 64'd0);
    rst_n = 1'b1;

    // "abc" with the real digest
    pl = '{8'h61, 8'h62, 8'h63};
    start_frame(3, 3, 0, 6);
    finish_frame();

    // leading garbage and RX bytes during digest output are ignored
    gb = '{8'h55, 8'hAA};
    start_frame(3, 3, 1, 6);
    finish_frame();

    // bad lengths: zero and MAX_LEN+1
    start_frame(0, 0, 0, 4);
    finish_frame();
    start_frame(MAX_LEN + 1, 0, 0, 4);
    finish_frame();

    // timeout mid-payload, then a clean frame
    pl = '{8'h61, 8'h62};
    start_frame(5, 2, 0, 4);
    finish_frame();
    pl = '{8'h61, 8'h62, 8'h63};
    start_frame(3, 3, 0, 4);
    finish_frame();

    // length boundaries: 1 and MAX_LEN
    rand_payload(1);
    rand_hash();
    start_frame(1, 1, 0, 4);
    finish_frame();
    rand_payload(MAX_LEN);
    rand_hash();
    start_frame(MAX_LEN, MAX_LEN, 0, 0);
    finish_frame();

    // randomized frames
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 48);
      rand_payload(len);
      rand_hash();
      for (int g = $urandom_range(0, 2); g > 0; g--) gb.push_back(8'($urandom_range(2, 255)));
      start_frame(len, len, f[0], 12);
      finish_frame();
    end

    // reset while the digest is being sent
    pl = '{8'h61, 8'h62, 8'h63};
    rand_hash();
    start_frame(3, 3, 0, 4);
    c = 0;
    while (tx_seen < base_tx + 5 && c < 5000) begin @(negedge clk); c++; end
    chk("reached_dig", 64'(tx_seen >= base_tx + 5), 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_tx.delete();
    exp_sha.delete();
    #1;
    chk("reset_mid_dig_outputs", outs(), 64'd0);
    repeat (4) @(negedge clk);
    chk("reset_hold_outputs", outs(), 64'd0);
    rst_n = 1'b1;
    cur_hash = ABC_HASH;
    start_frame(3, 3, 0, 4);
    finish_frame();

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
